// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default sizing for the FIFO write-port arbiter
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int DEF_WIDTH     = 32;
   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin pick: first set request at or after start, wrapping
module rr_priority_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [IDX_WIDTH-1:0] start,
   output logic [IDX_WIDTH-1:0] idx,
   output logic                 any
);

   localparam logic [IDX_WIDTH:0] NUM_REQ_EXT = (IDX_WIDTH+1)'(NUM_REQ);

   logic [IDX_WIDTH:0]   sum;
   logic [IDX_WIDTH-1:0] cand;

   // One extra bit on the sum lets the wrap work for non-power-of-two NUM_REQ.
   always_comb begin
      idx  = '0;
      any  = 1'b0;
      sum  = '0;
      cand = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, start} + (IDX_WIDTH+1)'(k);
         if (sum >= NUM_REQ_EXT) begin
            sum = sum - NUM_REQ_EXT;
         end
         cand = sum[IDX_WIDTH-1:0];
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-bounded sharing of the async FIFO write port
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int IDX_WIDTH = $clog2(NUM_REQ),
   parameter int CNT_WIDTH = $clog2(MAX_BURST+1)
) (
   input  logic                     wr_clk,
   input  logic                     sync_rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]       req_last,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic                     full,
   output logic                     wr_en,
   output logic [WIDTH-1:0]         wr_data,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     busy
);

   localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BURST-1);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_REQ-1);

   arb_state_t           state, state_nxt;
   logic [IDX_WIDTH-1:0] grant_idx, grant_idx_nxt;
   logic [IDX_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
   logic [CNT_WIDTH-1:0] beat_cnt, beat_cnt_nxt;
   logic [IDX_WIDTH-1:0] pick_idx;
   logic                 pick_any;
   logic                 g_valid;
   logic                 g_last;
   logic                 accept;
   logic                 burst_done;

   rr_priority_pick #(
      .NUM_REQ   (NUM_REQ),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_pick (
      .req   (req_valid),
      .start (rr_ptr),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign g_valid = req_valid[grant_idx];
   assign g_last  = req_last[grant_idx];

   // Gated by reset so an interrupted burst never writes a partial beat.
   assign accept = sync_rst_n && (state == BURST) && g_valid && !full;

   always_ff @(posedge wr_clk) begin
      if (!sync_rst_n) begin
         state     <= IDLE;
         grant_idx <= '0;
         rr_ptr    <= '0;
         beat_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         grant_idx <= grant_idx_nxt;
         rr_ptr    <= rr_ptr_nxt;
         beat_cnt  <= beat_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      grant_idx_nxt = grant_idx;
      rr_ptr_nxt    = rr_ptr;
      beat_cnt_nxt  = beat_cnt;
      burst_done    = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_nxt     = BURST;
               grant_idx_nxt = pick_idx;
               beat_cnt_nxt  = '0;
            end
         end
         BURST: begin
            // A withdrawn requester ends the burst even while the FIFO is full.
            if (!g_valid) begin
               burst_done = 1'b1;
            end else if (accept) begin
               if (g_last || (beat_cnt == LAST_BEAT)) begin
                  burst_done = 1'b1;
               end else begin
                  beat_cnt_nxt = beat_cnt + 1'b1;
               end
            end
            if (burst_done) begin
               state_nxt    = IDLE;
               beat_cnt_nxt = '0;
               rr_ptr_nxt   = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      req_ready = '0;
      grant     = '0;
      busy      = 1'b0;
      wr_en     = 1'b0;
      wr_data   = '0;
      if (sync_rst_n && (state == BURST)) begin
         busy                 = 1'b1;
         grant[grant_idx]     = 1'b1;
         req_ready[grant_idx] = !full;
         wr_en                = accept;
         if (accept) begin
            wr_data = req_data[grant_idx*WIDTH +: WIDTH];
         end
      end
   end

endmodule
